// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the timing generator and the pixel stage
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          en;
    logic [CW-1:0] column;
    logic [CW-1:0] row;
    logic          hsync;
    logic          vsync;
    logic          rgb_en;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output column, row, hsync, vsync, rgb_en, line_start, frame_start
    );

    modport slave (
        output en,
        input  column, row, hsync, vsync, rgb_en, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (optional VGA_PIPE_EN delays hsync/vsync/rgb_en by one tick)
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = 10
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_gen_if.master   vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Counters must be able to hold TOTAL-1 without aliasing.
    generate
        if ((64'd1 << CW) <= 64'(H_TOTAL) || (64'd1 << CW) <= 64'(V_TOTAL)) begin : g_cw_check
            $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          rgb_en_q, rgb_en_d;
    logic          flag_load;
    logic [CW-1:0] dec_h;
    logic [CW-1:0] dec_v;

    // Next raster position and the wrap pulses that accompany it.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (vif.en) begin
            if (h_q == H_LAST) begin
                h_d          = '0;
                line_start_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + ONE;
                end
            end else begin
                h_d = h_q + ONE;
            end
        end
    end

    // Flags decode the next position (zero skew) or, when pipelined, the position
    // being left on this tick so they trail column/row by exactly one pixel.
    always_comb begin
`ifdef VGA_PIPE_EN
        dec_h     = h_q;
        dec_v     = v_q;
        flag_load = vif.en;
`else
        dec_h     = h_d;
        dec_v     = v_d;
        flag_load = 1'b1;
`endif
        hsync_d  = ((dec_h >= HS_BEG) && (dec_h < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = ((dec_v >= VS_BEG) && (dec_v < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        rgb_en_d = (dec_h < H_ACT) && (dec_v < V_ACT);
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q           <= '0;
            v_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Level flag registers; reset to the levels that position (0,0) decodes to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            rgb_en_q <= 1'b1;
        end else if (flag_load) begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            rgb_en_q <= rgb_en_d;
        end
    end

    assign vif.column      = h_q;
    assign vif.row         = v_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.rgb_en      = rgb_en_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen (default and 7x5 raster)
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(10)) ifa ();
    vga_timing_gen_if #(.CW(3))  ifb ();

    vga_timing_gen dut_a (
        .clk (clk),
        .rst (rst),
        .vif (ifa.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .CW (3)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .vif (ifb.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    int   ha, va, hb, vb;
    logic ehs_a, evs_a, erg_a, els_a, efs_a;
    logic ehs_b, evs_b, erg_b, els_b, efs_b;
    int   cnt_ls_a, cnt_fs_a, cnt_fs_b;

    function automatic logic [2:0] dec_a(int h, int v);
        return {(h >= 656 && h < 752) ? 1'b0 : 1'b1,
                (v >= 490 && v < 492) ? 1'b0 : 1'b1,
                (h < 640 && v < 480) ? 1'b1 : 1'b0};
    endfunction

    function automatic logic [2:0] dec_b(int h, int v);
        return {(h == 5) ? 1'b1 : 1'b0,
                (v == 3) ? 1'b0 : 1'b1,
                (h < 4 && v < 2) ? 1'b1 : 1'b0};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ha = 0; va = 0; hb = 0; vb = 0;
        ehs_a = 1'b1; evs_a = 1'b1; erg_a = 1'b1; els_a = 1'b0; efs_a = 1'b0;
        ehs_b = 1'b0; evs_b = 1'b1; erg_b = 1'b1; els_b = 1'b0; efs_b = 1'b0;
    endtask

    task automatic check_all();
        chk("a_column", int'(ifa.column), ha);
        chk("a_row", int'(ifa.row), va);
        chk("a_hsync", int'(ifa.hsync), int'(ehs_a));
        chk("a_vsync", int'(ifa.vsync), int'(evs_a));
        chk("a_rgb_en", int'(ifa.rgb_en), int'(erg_a));
        chk("a_line_start", int'(ifa.line_start), int'(els_a));
        chk("a_frame_start", int'(ifa.frame_start), int'(efs_a));
        chk("b_column", int'(ifb.column), hb);
        chk("b_row", int'(ifb.row), vb);
        chk("b_hsync", int'(ifb.hsync), int'(ehs_b));
        chk("b_vsync", int'(ifb.vsync), int'(evs_b));
        chk("b_rgb_en", int'(ifb.rgb_en), int'(erg_b));
        chk("b_line_start", int'(ifb.line_start), int'(els_b));
        chk("b_frame_start", int'(ifb.frame_start), int'(efs_b));
    endtask

    task automatic step(input logic ea, input logic eb);
        ifa.en = ea;
        ifb.en = eb;
        @(posedge clk);
        #1;
        els_a = 1'b0; efs_a = 1'b0;
        if (ea) begin
`ifdef VGA_PIPE_EN
            {ehs_a, evs_a, erg_a} = dec_a(ha, va);
`endif
            if (ha == 799) begin
                ha = 0; els_a = 1'b1;
                if (va == 524) begin va = 0; efs_a = 1'b1; end
                else va = va + 1;
            end else ha = ha + 1;
`ifndef VGA_PIPE_EN
            {ehs_a, evs_a, erg_a} = dec_a(ha, va);
`endif
        end
        els_b = 1'b0; efs_b = 1'b0;
        if (eb) begin
`ifdef VGA_PIPE_EN
            {ehs_b, evs_b, erg_b} = dec_b(hb, vb);
`endif
            if (hb == 6) begin
                hb = 0; els_b = 1'b1;
                if (vb == 4) begin vb = 0; efs_b = 1'b1; end
                else vb = vb + 1;
            end else hb = hb + 1;
`ifndef VGA_PIPE_EN
            {ehs_b, evs_b, erg_b} = dec_b(hb, vb);
`endif
        end
        if (ifa.line_start === 1'b1) cnt_ls_a++;
        if (ifa.frame_start === 1'b1) cnt_fs_a++;
        if (ifb.frame_start === 1'b1) cnt_fs_b++;
        check_all();
    endtask

    initial begin
        rst = 1'b0;
        ifa.en = 1'b0;
        ifb.en = 1'b0;
        cnt_ls_a = 0; cnt_fs_a = 0; cnt_fs_b = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all();
        rst = 1'b1;

        // Default raster, two full lines plus 100 pixels; small raster held.
        for (int i = 0; i < 1700; i++) step(1'b1, 1'b0);
        chk("a_col_after_1700", int'(ifa.column), 100);
        chk("a_row_after_1700", int'(ifa.row), 2);
        chk("a_line_pulses", cnt_ls_a, 2);
        chk("a_frame_pulses", cnt_fs_a, 0);
        chk("b_held_col", int'(ifb.column), 0);

        // Small raster: one full frame of 35 ticks lands on (0,0) with both pulses.
        for (int i = 0; i < 35; i++) step(1'b0, 1'b1);
        chk("b_wrap_col", int'(ifb.column), 0);
        chk("b_wrap_row", int'(ifb.row), 0);
        chk("b_wrap_line_start", int'(ifb.line_start), 1);
        chk("b_wrap_frame_start", int'(ifb.frame_start), 1);
        cnt_fs_b = 0;
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1);
        chk("b_two_frames", cnt_fs_b, 2);

        // en every other clock: a frame now takes 70 clocks.
        cnt_fs_b = 0;
        for (int i = 0; i < 140; i++) step(1'b0, (i % 2) == 0);
        chk("b_toggle_frames", cnt_fs_b, 2);
        chk("b_toggle_col", int'(ifb.column), 0);
        chk("b_toggle_row", int'(ifb.row), 0);
        chk("a_held_col", int'(ifa.column), 100);
        chk("a_held_row", int'(ifa.row), 2);

        // Asynchronous reset between clock edges, then recovery from (0,0).
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1'b1;
        step(1'b1, 1'b1);
        chk("a_recover_col", int'(ifa.column), 1);
        chk("b_recover_col", int'(ifb.column), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
